dtcl_afpm_pipe: RTL and testbench

// Pipelined, parametrised DTCL approximate FP32 multiplier (decomposition, truncation,

---
 rtl/dtcl_afpm_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_dtcl_afpm_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dtcl_afpm_pipe.sv
// Three-stage valid/ready DTCL approximate FP32 multiplier with per-op exact/approx mode.
// Stages: S1 operand decode and chunk quantisation, S2 partial products, S3 normalise/round-off and pack.
`timescale 1ns/1ps
module dtcl_afpm_pipe #(
    parameter int E         = 8,
    parameter int A         = 8,
    parameter int K         = 2,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_a,
    input  logic [31:0]          in_b,
    input  logic                 in_approx,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_product,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [2:0]           out_flags,
    output logic [31:0]          approx_count
);

    localparam int PW = 2 * (E + A);
    localparam int NC = A / K;

    generate
        if (E < 1 || E + A > 24) begin : g_bad_ea
            $error("dtcl_afpm_pipe: E must be >= 1 and E+A <= 24");
        end
        if (A < K || (A % K) != 0) begin : g_bad_a
            $error("dtcl_afpm_pipe: A must be a non-zero multiple of K");
        end
        if (K < 2 || (K & (K - 1)) != 0) begin : g_bad_k
            $error("dtcl_afpm_pipe: K must be a power of two >= 2");
        end
    endgenerate

    // The first bit dropped below Y is folded into Y's LSB; a zero is appended so E+A=24 folds nothing.
    function automatic logic [A-1:0] get_y(input logic [23:0] sig);
        logic [24:0] sig_ext;
        logic [A-1:0] y;
        sig_ext = {sig, 1'b0};
        y       = sig[23-E -: A];
        y[0]    = y[0] | sig_ext[24-E-A];
        return y;
    endfunction

    function automatic logic [A-1:0] quantise(input logic [A-1:0] y);
        logic [A-1:0] q;
        q = '0;
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < K; i++) begin
                if (y[c*K+i]) begin
                    q[c*K +: K] = '0;
                    q[c*K+i]    = 1'b1;
                end
            end
        end
        return q;
    endfunction

    logic advance;
    logic accept;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    logic [7:0]  exp_a, exp_b;
    logic [23:0] sig_a, sig_b;
    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

    always_comb begin
        exp_a  = in_a[30:23];
        exp_b  = in_b[30:23];
        sig_a  = {exp_a != 8'd0, in_a[22:0]};
        sig_b  = {exp_b != 8'd0, in_b[22:0]};
        zero_a = (exp_a == 8'd0);
        zero_b = (exp_b == 8'd0);
        inf_a  = (exp_a == 8'hFF) && (in_a[22:0] == 23'd0);
        inf_b  = (exp_b == 8'hFF) && (in_b[22:0] == 23'd0);
        nan_a  = (exp_a == 8'hFF) && (in_a[22:0] != 23'd0);
        nan_b  = (exp_b == 8'hFF) && (in_b[22:0] != 23'd0);
    end

    logic                 s1_valid, s1_approx, s1_sign, s1_nan, s1_inf, s1_zero;
    logic signed [9:0]    s1_exp;
    logic [23:0]          s1_siga, s1_sigb;
    logic [E-1:0]         s1_xa, s1_xb;
    logic [A-1:0]         s1_ya, s1_qa, s1_qb;
    logic [TAG_WIDTH-1:0] s1_tag;

    logic                 s2_valid, s2_approx, s2_sign, s2_nan, s2_inf, s2_zero;
    logic signed [9:0]    s2_exp;
    logic [47:0]          s2_pp;
    logic [TAG_WIDTH-1:0] s2_tag;

    logic [PW-1:0] pp_ap_c;
    logic [47:0]   pp_ex_c;

    always_comb begin
        pp_ap_c = ((PW'(s1_xa) * PW'(s1_xb)) << (2 * A))
                + ((PW'(s1_xa) * PW'(s1_qb) + PW'(s1_xb) * PW'(s1_qa)) << A)
                + PW'(s1_ya) * PW'(s1_qb);
        pp_ex_c = 48'(s1_siga) * 48'(s1_sigb);
    end

    // Stage payloads need no reset: their valid bits gate everything downstream.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_approx <= in_approx;
            s1_sign   <= in_a[31] ^ in_b[31];
            s1_nan    <= nan_a || nan_b || (zero_a && inf_b) || (inf_a && zero_b);
            s1_inf    <= inf_a || inf_b;
            s1_zero   <= zero_a || zero_b;
            s1_exp    <= $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
            s1_siga   <= sig_a;
            s1_sigb   <= sig_b;
            s1_xa     <= sig_a[23 -: E];
            s1_xb     <= sig_b[23 -: E];
            s1_ya     <= get_y(sig_a);
            s1_qa     <= quantise(get_y(sig_a));
            s1_qb     <= quantise(get_y(sig_b));
            s1_tag    <= in_tag;

            s2_approx <= s1_approx;
            s2_sign   <= s1_sign;
            s2_nan    <= s1_nan;
            s2_inf    <= s1_inf;
            s2_zero   <= s1_zero;
            s2_exp    <= s1_exp;
            s2_pp     <= s1_approx ? 48'(pp_ap_c) : pp_ex_c;
            s2_tag    <= s1_tag;
        end
    end

    logic [PW-1:0]     pp_ap, norm_ap;
    logic [47:0]       norm_ex;
    logic [22:0]       frac_ap, frac_ex, frac;
    logic              adj;
    logic signed [9:0] e;
    logic [31:0]       res_product;
    logic [2:0]        res_flags;

    // The bit just below the MSB-of-product sits at the top after the conditional shift;
    // appending 23 zeros pads the fraction when fewer than 23 bits remain below it.
    always_comb begin
        pp_ap   = s2_pp[PW-1:0];
        norm_ap = pp_ap[PW-1] ? pp_ap : (pp_ap << 1);
        norm_ex = s2_pp[47] ? s2_pp : (s2_pp << 1);
        frac_ap = 23'({norm_ap, 23'd0} >> (PW - 1));
        frac_ex = 23'({norm_ex, 23'd0} >> 47);
        frac    = s2_approx ? frac_ap : frac_ex;
        adj     = s2_approx ? pp_ap[PW-1] : s2_pp[47];
        e       = s2_exp + $signed({9'd0, adj});

        res_product = {s2_sign ^ 1'b0, e[7:0], frac};
        res_flags   = 3'b000;
        if (s2_nan) begin
            res_product = 32'h7FFF_FFFF;
            res_flags   = 3'b100;
        end else if (s2_inf) begin
            res_product = {s2_sign, 31'h7F80_0000};
            res_flags   = 3'b010;
        end else if (s2_zero) begin
            res_product = {s2_sign, 31'd0};
        end else if (e >= 10'sd255) begin
            res_product = {s2_sign, 31'h7F80_0000};
            res_flags   = 3'b010;
        end else if (e <= 10'sd0) begin
            res_product = {s2_sign, 31'd0};
            res_flags   = 3'b001;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            out_valid    <= 1'b0;
            out_product  <= 32'd0;
            out_tag      <= '0;
            out_flags    <= 3'b000;
            approx_count <= 32'd0;
        end else begin
            if (accept && in_approx && approx_count != 32'hFFFF_FFFF) begin
                approx_count <= approx_count + 32'd1;
            end
            if (advance) begin
                s1_valid  <= in_valid;
                s2_valid  <= s1_valid;
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_product <= res_product;
                    out_tag     <= s2_tag;
                    out_flags   <= res_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_dtcl_afpm_pipe.sv
// Directed self-checking bench for dtcl_afpm_pipe: arithmetic vectors, specials,
// back-pressure streaming and mid-flight reset, each scenario in its own task.
`timescale 1ns/1ps
module tb_dtcl_afpm_pipe;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        in_approx;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic [3:0]  out_tag;
    logic [2:0]  out_flags;
    logic [31:0] approx_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    dtcl_afpm_pipe #(.E(8), .A(8), .K(2), .TAG_WIDTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_approx   (in_approx),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag),
        .out_flags   (out_flags),
        .approx_count(approx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one op into an empty pipeline and waits (bounded) for its result; lat=99 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ap,
                          input logic [3:0] tag, output logic [31:0] p,
                          output logic [2:0] f, output logic [3:0] t, output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_approx = ap; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) lat = 99;
        p = out_product; f = out_flags; t = out_tag;
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_approx = 1'b0; in_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_product !== 32'd0) begin errors++; $display("[TB] FAIL reset_product: got %h expected 00000000", out_product); end
        checks++; if (out_tag !== 4'd0 || out_flags !== 3'd0) begin errors++; $display("[TB] FAIL reset_tag_flags: got %h/%b expected 0/000", out_tag, out_flags); end
        checks++; if (approx_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", approx_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        reset_n = 1'b1;
        exp_count = 0;
    endtask

    task automatic test_basic();
        logic [31:0] p; logic [2:0] f; logic [3:0] t; int lat;
        run_op(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 4'h3, p, f, t, lat);
        exp_count++;
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 3", lat); end
        checks++; if (p !== 32'h4010_0000) begin errors++; $display("[TB] FAIL basic_product: got %h expected 40100000", p); end
        checks++; if (f !== 3'b000) begin errors++; $display("[TB] FAIL basic_flags: got %b expected 000", f); end
        checks++; if (t !== 4'h3) begin errors++; $display("[TB] FAIL basic_tag: got %h expected 3", t); end
        checks++; if (approx_count !== 32'(exp_count)) begin errors++; $display("[TB] FAIL basic_count: got %0d expected %0d", approx_count, exp_count); end
        run_op(32'hBFC0_0000, 32'h3FC0_0000, 1'b1, 4'h4, p, f, t, lat);
        exp_count++;
        checks++; if (p !== 32'hC010_0000) begin errors++; $display("[TB] FAIL basic_negative: got %h expected c0100000", p); end
    endtask

    task automatic test_approx_vs_exact();
        logic [31:0] p; logic [2:0] f; logic [3:0] t; int lat;
        run_op(32'h3F80_0000, 32'h3F80_3000, 1'b1, 4'h5, p, f, t, lat);
        exp_count++;
        checks++; if (p !== 32'h3F80_2000) begin errors++; $display("[TB] FAIL approx_quantised: got %h expected 3f802000", p); end
        run_op(32'h3F80_0000, 32'h3F80_3000, 1'b0, 4'h6, p, f, t, lat);
        checks++; if (p !== 32'h3F80_3000) begin errors++; $display("[TB] FAIL exact_product: got %h expected 3f803000", p); end
        checks++; if (approx_count !== 32'(exp_count)) begin errors++; $display("[TB] FAIL exact_no_count: got %0d expected %0d", approx_count, exp_count); end
    endtask

    task automatic test_range();
        logic [31:0] p; logic [2:0] f; logic [3:0] t; int lat;
        run_op(32'h7F00_0000, 32'h7F00_0000, 1'b0, 4'h7, p, f, t, lat);
        checks++; if (p !== 32'h7F80_0000 || f !== 3'b010) begin errors++; $display("[TB] FAIL overflow: got %h/%b expected 7f800000/010", p, f); end
        run_op(32'h0080_0000, 32'h0080_0000, 1'b1, 4'h8, p, f, t, lat);
        exp_count++;
        checks++; if (p !== 32'h0000_0000 || f !== 3'b001) begin errors++; $display("[TB] FAIL underflow: got %h/%b expected 00000000/001", p, f); end
    endtask

    task automatic test_specials();
        logic [31:0] p; logic [2:0] f; logic [3:0] t; int lat;
        run_op(32'h0000_0000, 32'h7F80_0000, 1'b0, 4'h9, p, f, t, lat);
        checks++; if (p !== 32'h7FFF_FFFF || f !== 3'b100) begin errors++; $display("[TB] FAIL zero_times_inf: got %h/%b expected 7fffffff/100", p, f); end
        run_op(32'h0000_0001, 32'h4000_0000, 1'b0, 4'hA, p, f, t, lat);
        checks++; if (p !== 32'h0000_0000 || f !== 3'b000) begin errors++; $display("[TB] FAIL subnormal_flush: got %h/%b expected 00000000/000", p, f); end
        run_op(32'hFF80_0000, 32'h4000_0000, 1'b0, 4'hB, p, f, t, lat);
        checks++; if (p !== 32'hFF80_0000 || f !== 3'b010) begin errors++; $display("[TB] FAIL neg_inf: got %h/%b expected ff800000/010", p, f); end
        run_op(32'h7FC0_0000, 32'h3F80_0000, 1'b0, 4'hC, p, f, t, lat);
        checks++; if (p !== 32'h7FFF_FFFF || f !== 3'b100) begin errors++; $display("[TB] FAIL nan_in: got %h/%b expected 7fffffff/100", p, f); end
        run_op(32'h8000_0000, 32'h4000_0000, 1'b0, 4'hD, p, f, t, lat);
        checks++; if (p !== 32'h8000_0000 || f !== 3'b000) begin errors++; $display("[TB] FAIL neg_zero: got %h/%b expected 80000000/000", p, f); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b_vals [6];
        logic [31:0] got_p;
        logic [3:0]  got_t;
        int sent, recv;
        b_vals = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                   32'h40A0_0000, 32'h3F00_0000, 32'hC000_0000};
        sent = 0; recv = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            out_ready = !(k >= 2 && k <= 6);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                in_a = 32'h3F80_0000; in_b = b_vals[sent];
                in_approx = sent[0]; in_tag = 4'(sent + 4);
            end
            #1;
            if (k == 2 || k == 7) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready_c%0d: got %b expected 1", k, in_ready); end
            end
            if (k >= 3 && k <= 6) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stream_stall_c%0d: got %b expected 0", k, in_ready); end
            end
            if (k == 6) begin
                checks++; if (out_valid !== 1'b1 || out_tag !== 4'd4 || out_product !== 32'h4000_0000) begin
                    errors++; $display("[TB] FAIL stream_hold: got %b/%h/%h expected 1/4/40000000", out_valid, out_tag, out_product);
                end
            end
            if (out_valid && out_ready) begin
                got_p = out_product; got_t = out_tag;
                checks++;
                if (recv >= 6) begin
                    errors++; $display("[TB] FAIL stream_extra: got tag %h expected no output", got_t);
                end else if (got_t !== 4'(recv + 4) || got_p !== b_vals[recv]) begin
                    errors++; $display("[TB] FAIL stream_out%0d: got %h/%h expected %h/%h", recv, got_t, got_p, 4'(recv + 4), b_vals[recv]);
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                if (sent[0]) exp_count++;
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (recv !== 6) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 6", recv); end
        checks++; if (approx_count !== 32'(exp_count)) begin errors++; $display("[TB] FAIL stream_approx_count: got %0d expected %0d", approx_count, exp_count); end
    endtask

    task automatic test_reset_inflight();
        int seen;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_a = 32'h3FC0_0000; in_b = 32'h4000_0000; in_approx = 1'b1;
            in_tag = 4'(i + 1); in_valid = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (approx_count !== 32'(exp_count + 2)) begin errors++; $display("[TB] FAIL inflight_count: got %0d expected %0d", approx_count, exp_count + 2); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL inflight_out_valid: got %b expected 0", out_valid); end
        checks++; if (approx_count !== 32'd0) begin errors++; $display("[TB] FAIL inflight_count_clear: got %0d expected 0", approx_count); end
        reset_n = 1'b1;
        exp_count = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL inflight_discard: got %0d outputs expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_approx_vs_exact();
        test_range();
        test_specials();
        test_back_to_back();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
